// File: rtl/riscv_store_tag_unit_pkg.sv
// Shared definitions for the DIFT store-side tag path: TPR field positions,
// propagation ALU mode encodings, store-tag FSM states and a byte-mask helper.
package riscv_store_tag_unit_pkg;

  // Tag Propagation Register field positions for the load/store class.
  localparam int LOADSTORE_LOW            = 14;
  localparam int LOADSTORE_HIGH           = 15;
  localparam int LOADSTORE_EN_DEST        = 16;
  localparam int LOADSTORE_EN_SOURCE_ADDR = 17;
  localparam int LOADSTORE_EN_SOURCE      = 18;

  // Propagation ALU modes, shared with the load-side unit.
  localparam logic [1:0] ALU_MODE_AND   = 2'b00;
  localparam logic [1:0] ALU_MODE_OR    = 2'b01;
  localparam logic [1:0] ALU_MODE_CLEAR = 2'b10;
  localparam logic [1:0] ALU_MODE_OLD   = 2'b11;

  // Store size encodings as presented by the LSU.
  localparam logic [1:0] STORE_SIZE_BYTE = 2'b00;
  localparam logic [1:0] STORE_SIZE_HALF = 2'b01;
  localparam logic [1:0] STORE_SIZE_WORD = 2'b10;

  // Store-tag FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SKIP  = 3'd1,
    ST_REQ0  = 3'd2,
    ST_WAIT0 = 3'd3,
    ST_REQ1  = 3'd4,
    ST_WAIT1 = 3'd5
  } st_tag_state_e;

  // Two-word byte-enable mask: low nibble belongs to the aligned word holding
  // the first byte, high nibble to the following word. Size 11 acts as a word.
  function automatic logic [7:0] storeByteMask(input logic [1:0] size,
                                               input logic [1:0] offset);
    logic [7:0] base;
    case (size)
      STORE_SIZE_BYTE: base = 8'h01;
      STORE_SIZE_HALF: base = 8'h03;
      default:         base = 8'h0F;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/riscv_store_tag_unit_propagation.sv
// Store-side tag propagation: decodes the load/store TPR fields and combines
// the address and data source tags into the tag written to memory.
module riscv_store_propagation
  import riscv_store_tag_unit_pkg::*;
(
  input  logic        rs1_tag_i,
  input  logic        rs2_tag_i,
  input  logic [31:0] tpr_i,
  output logic        tag_o,
  output logic        skip_o
);

  logic       opA;
  logic       opB;
  logic [1:0] mode;
  logic       unusedTprBits;

  assign opA  = rs1_tag_i & tpr_i[LOADSTORE_EN_SOURCE_ADDR];
  assign opB  = rs2_tag_i & tpr_i[LOADSTORE_EN_SOURCE];
  assign mode = tpr_i[LOADSTORE_HIGH:LOADSTORE_LOW];

  // Only the load/store fields matter here; fold the rest away.
  assign unusedTprBits = ^tpr_i;

  // Select the propagated tag; OLD mode leaves memory tags untouched.
  always_comb begin
    tag_o  = 1'b0;
    skip_o = 1'b0;
    case (mode)
      ALU_MODE_AND:   tag_o = opA & opB;
      ALU_MODE_OR:    tag_o = opA | opB;
      ALU_MODE_CLEAR: tag_o = 1'b0;
      ALU_MODE_OLD:   skip_o = 1'b1;
      default:        tag_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_store_tag_unit.sv
// Store tag unit: captures an accepted store, computes its memory tag and
// writes it to the byte-granular tag memory, splitting misaligned stores
// into two word transactions. The LSU holds the store until st_done_o.
module riscv_store_tag_unit
  import riscv_store_tag_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  input  logic [1:0]            st_size_i,
  input  logic                  rs1_tag_i,
  input  logic                  rs2_tag_i,
  input  logic [31:0]           tpr_i,
  output logic                  st_done_o,
  output logic                  tag_req_o,
  input  logic                  tag_gnt_i,
  output logic [ADDR_WIDTH-1:0] tag_addr_o,
  output logic                  tag_we_o,
  output logic [3:0]            tag_be_o,
  output logic [3:0]            tag_wdata_o,
  input  logic                  tag_rvalid_i
);

  st_tag_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] wordAddr_q;
  logic [7:0]            byteEn_q;
  logic                  tagBit_q;

  logic                  accept;
  logic                  misaligned;
  logic [7:0]            acceptMask;
  logic                  computeTag;
  logic                  skipWrite;

  riscv_store_propagation u_propagation (
    .rs1_tag_i (rs1_tag_i),
    .rs2_tag_i (rs2_tag_i),
    .tpr_i     (tpr_i),
    .tag_o     (computeTag),
    .skip_o    (skipWrite)
  );

  assign st_ready_o = (state_q == ST_IDLE);
  assign accept     = st_valid_i & st_ready_o;
  assign acceptMask = storeByteMask(st_size_i, st_addr_i[1:0]);
  assign misaligned = |byteEn_q[7:4];
  assign tag_we_o   = tag_req_o;

  // Capture everything needed for the transaction at accept so later TPR or
  // operand changes in the pipeline cannot disturb an in-flight update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wordAddr_q <= '0;
      byteEn_q   <= '0;
      tagBit_q   <= 1'b0;
    end else if (accept) begin
      wordAddr_q <= {st_addr_i[ADDR_WIDTH-1:2], 2'b00};
      byteEn_q   <= acceptMask;
      tagBit_q   <= computeTag;
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, request and completion logic; one outstanding transaction.
  always_comb begin
    state_d   = state_q;
    tag_req_o = 1'b0;
    st_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = skipWrite ? ST_SKIP : ST_REQ0;
        end
      end
      ST_SKIP: begin
        st_done_o = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_REQ0: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) begin
          state_d = ST_WAIT0;
        end
      end
      ST_WAIT0: begin
        if (tag_rvalid_i) begin
          if (misaligned) begin
            state_d = ST_REQ1;
          end else begin
            st_done_o = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_REQ1: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) begin
          state_d = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (tag_rvalid_i) begin
          st_done_o = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Drive the tag-memory payload only while a request is up; the second word
  // follows the first and wraps around the top of the address space.
  always_comb begin
    tag_addr_o  = '0;
    tag_be_o    = 4'h0;
    tag_wdata_o = 4'h0;
    case (state_q)
      ST_REQ0: begin
        tag_addr_o  = wordAddr_q;
        tag_be_o    = byteEn_q[3:0];
        tag_wdata_o = {4{tagBit_q}};
      end
      ST_REQ1: begin
        tag_addr_o  = wordAddr_q + ADDR_WIDTH'(4);
        tag_be_o    = byteEn_q[7:4];
        tag_wdata_o = {4{tagBit_q}};
      end
      default: begin
        tag_addr_o  = '0;
        tag_be_o    = 4'h0;
        tag_wdata_o = 4'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_store_tag_unit.sv
// Directed bench for the store tag unit: aligned, misaligned, skipped,
// stalled-grant, disabled-source and reset-in-flight stores.
module tb_riscv_store_tag_unit;
  import riscv_store_tag_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [1:0]  st_size_i;
  logic        rs1_tag_i;
  logic        rs2_tag_i;
  logic [31:0] tpr_i;
  logic        st_done_o;
  logic        tag_req_o;
  logic        tag_gnt_i;
  logic [31:0] tag_addr_o;
  logic        tag_we_o;
  logic [3:0]  tag_be_o;
  logic [3:0]  tag_wdata_o;
  logic        tag_rvalid_i;

  int checks;
  int failures;

  riscv_store_tag_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid_i   (st_valid_i),
    .st_ready_o   (st_ready_o),
    .st_addr_i    (st_addr_i),
    .st_size_i    (st_size_i),
    .rs1_tag_i    (rs1_tag_i),
    .rs2_tag_i    (rs2_tag_i),
    .tpr_i        (tpr_i),
    .st_done_o    (st_done_o),
    .tag_req_o    (tag_req_o),
    .tag_gnt_i    (tag_gnt_i),
    .tag_addr_o   (tag_addr_o),
    .tag_we_o     (tag_we_o),
    .tag_be_o     (tag_be_o),
    .tag_wdata_o  (tag_wdata_o),
    .tag_rvalid_i (tag_rvalid_i)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] makeTpr(input logic [1:0] mode,
                                          input logic enAddr,
                                          input logic enSrc);
    logic [31:0] t;
    t = 32'h0;
    t[LOADSTORE_HIGH:LOADSTORE_LOW] = mode;
    t[LOADSTORE_EN_SOURCE_ADDR]     = enAddr;
    t[LOADSTORE_EN_SOURCE]          = enSrc;
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr,
                               input logic [1:0] size, input logic rs1,
                               input logic rs2, input logic [31:0] tpr);
    st_valid_i = valid;
    st_addr_i  = addr;
    st_size_i  = size;
    rs1_tag_i  = rs1;
    rs2_tag_i  = rs2;
    tpr_i      = tpr;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b1;
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_ready", st_ready_o, 1);
    checkOutput("rst_done",  st_done_o, 0);
    checkOutput("rst_req",   tag_req_o, 0);
    checkOutput("rst_addr",  tag_addr_o, 0);
    checkOutput("rst_be",    tag_be_o, 0);
    checkOutput("rst_wdata", tag_wdata_o, 0);
    #9 rst_n = 1'b1;

    // Aligned word store, OR mode, data tag only -> tag 1.
    tick();
    applyStimulus(1'b1, 32'h100, STORE_SIZE_WORD, 1'b0, 1'b1,
                  makeTpr(ALU_MODE_OR, 1'b1, 1'b1));
    tag_gnt_i = 1'b1;
    #1;
    checkOutput("t1_accept_ready", st_ready_o, 1);
    checkOutput("t1_accept_req",   tag_req_o, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t1_req",   tag_req_o, 1);
    checkOutput("t1_we",    tag_we_o, 1);
    checkOutput("t1_addr",  tag_addr_o, 32'h100);
    checkOutput("t1_be",    tag_be_o, 4'hF);
    checkOutput("t1_wdata", tag_wdata_o, 4'hF);
    checkOutput("t1_busy",  st_ready_o, 0);
    checkOutput("t1_nodone", st_done_o, 0);
    tick();
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b1;
    #1;
    checkOutput("t1_done",      st_done_o, 1);
    checkOutput("t1_wait_req",  tag_req_o, 0);
    tick();
    tag_rvalid_i = 1'b0;
    #1;
    checkOutput("t1_idle_ready", st_ready_o, 1);
    checkOutput("t1_idle_done",  st_done_o, 0);

    // Misaligned half store at 0x203, AND mode -> two word writes.
    applyStimulus(1'b1, 32'h203, STORE_SIZE_HALF, 1'b1, 1'b1,
                  makeTpr(ALU_MODE_AND, 1'b1, 1'b1));
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t2_req0",   tag_req_o, 1);
    checkOutput("t2_addr0",  tag_addr_o, 32'h200);
    checkOutput("t2_be0",    tag_be_o, 4'h8);
    checkOutput("t2_wdata0", tag_wdata_o, 4'hF);
    tag_gnt_i = 1'b1;
    tick();
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b1;
    #1;
    checkOutput("t2_wait0_req",  tag_req_o, 0);
    checkOutput("t2_wait0_done", st_done_o, 0);
    tick();
    tag_rvalid_i = 1'b0;
    #1;
    checkOutput("t2_req1",   tag_req_o, 1);
    checkOutput("t2_addr1",  tag_addr_o, 32'h204);
    checkOutput("t2_be1",    tag_be_o, 4'h1);
    checkOutput("t2_wdata1", tag_wdata_o, 4'hF);
    checkOutput("t2_busy",   st_ready_o, 0);
    tag_gnt_i = 1'b1;
    tick();
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b1;
    #1;
    checkOutput("t2_done", st_done_o, 1);
    tick();
    tag_rvalid_i = 1'b0;
    #1;
    checkOutput("t2_idle_ready", st_ready_o, 1);

    // Byte store with OLD mode: no traffic, done one cycle after accept.
    applyStimulus(1'b1, 32'h011, STORE_SIZE_BYTE, 1'b1, 1'b1,
                  makeTpr(ALU_MODE_OLD, 1'b1, 1'b1));
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t3_done",  st_done_o, 1);
    checkOutput("t3_req",   tag_req_o, 0);
    checkOutput("t3_ready", st_ready_o, 0);
    tick();
    #1;
    checkOutput("t3_idle_ready", st_ready_o, 1);
    checkOutput("t3_idle_done",  st_done_o, 0);
    checkOutput("t3_idle_req",   tag_req_o, 0);

    // CLEAR mode word store with grant withheld three cycles.
    applyStimulus(1'b1, 32'h40, STORE_SIZE_WORD, 1'b1, 1'b1,
                  makeTpr(ALU_MODE_CLEAR, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput($sformatf("t4_stall_req%0d", i),   tag_req_o, 1);
      checkOutput($sformatf("t4_stall_addr%0d", i),  tag_addr_o, 32'h40);
      checkOutput($sformatf("t4_stall_be%0d", i),    tag_be_o, 4'hF);
      checkOutput($sformatf("t4_stall_wdata%0d", i), tag_wdata_o, 4'h0);
    end
    tick();
    tag_gnt_i = 1'b1;
    #1;
    checkOutput("t4_gnt_req", tag_req_o, 1);
    tick();
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b1;
    #1;
    checkOutput("t4_done", st_done_o, 1);
    tick();
    tag_rvalid_i = 1'b0;

    // Data source disabled: OR of (0, masked 1) -> tag 0.
    applyStimulus(1'b1, 32'h80, STORE_SIZE_WORD, 1'b0, 1'b1,
                  makeTpr(ALU_MODE_OR, 1'b1, 1'b0));
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    tag_gnt_i = 1'b1;
    #1;
    checkOutput("t5_req",   tag_req_o, 1);
    checkOutput("t5_wdata", tag_wdata_o, 4'h0);
    checkOutput("t5_be",    tag_be_o, 4'hF);
    tick();
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b1;
    #1;
    checkOutput("t5_done", st_done_o, 1);
    tick();
    tag_rvalid_i = 1'b0;

    // Misaligned word at the top of memory; reset while in WAIT1.
    applyStimulus(1'b1, 32'hFFFF_FFFE, STORE_SIZE_WORD, 1'b1, 1'b0,
                  makeTpr(ALU_MODE_OR, 1'b1, 1'b1));
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t6_addr0",  tag_addr_o, 32'hFFFF_FFFC);
    checkOutput("t6_be0",    tag_be_o, 4'hC);
    checkOutput("t6_wdata0", tag_wdata_o, 4'hF);
    tag_gnt_i = 1'b1;
    tick();
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b1;
    #1;
    checkOutput("t6_wait0_done", st_done_o, 0);
    tick();
    tag_rvalid_i = 1'b0;
    #1;
    checkOutput("t6_req1",  tag_req_o, 1);
    checkOutput("t6_addr1", tag_addr_o, 32'h0);
    checkOutput("t6_be1",   tag_be_o, 4'h3);
    tag_gnt_i = 1'b1;
    tick();
    tag_gnt_i = 1'b0;
    #1;
    checkOutput("t6_wait1_req",   tag_req_o, 0);
    checkOutput("t6_wait1_ready", st_ready_o, 0);
    rst_n        = 1'b0;
    tag_rvalid_i = 1'b1;
    #1;
    checkOutput("t6_rst_req",   tag_req_o, 0);
    checkOutput("t6_rst_done",  st_done_o, 0);
    checkOutput("t6_rst_ready", st_ready_o, 1);
    #1 rst_n = 1'b1;
    tick();
    #1;
    checkOutput("t6_stray_done",  st_done_o, 0);
    checkOutput("t6_stray_req",   tag_req_o, 0);
    checkOutput("t6_stray_ready", st_ready_o, 1);
    tick();
    tag_rvalid_i = 1'b0;
    #1;
    checkOutput("t6_final_ready", st_ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
